fp_flag_collector: RTL and testbench

Accumulates per-operation floating-point exception flags into sticky status bits and saturating per-flag event counters, and serves them to a controller over a request/response read port with optional clear-on-read. Sits downstream of the FPU flag outputs (the consumer side of the flag interface) and drives a maskable exception interrupt.

---
 rtl/fp_flag_collector_if.sv | 27 ++
 rtl/fp_flag_collector.sv | 91 +++++++++
 tb/tb_fp_flag_collector.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fp_flag_collector_if.sv
// Flag-input, mask and read-port signals shared between the FPU/controller side
// and the flag collector.
interface fp_flag_collector_if #(
    parameter int CNT_W = 8
);
    logic             flag_valid;
    logic [3:0]       flag_in;
    logic             mask_we;
    logic [3:0]       mask_in;
    logic             rd_req;
    logic [2:0]       rd_sel;
    logic             rd_clr;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_data;
    logic [3:0]       sticky;
    logic             irq;

    modport master (
        output flag_valid, flag_in, mask_we, mask_in, rd_req, rd_sel, rd_clr,
        input  rd_valid, rd_data, sticky, irq
    );

    modport slave (
        input  flag_valid, flag_in, mask_we, mask_in, rd_req, rd_sel, rd_clr,
        output rd_valid, rd_data, sticky, irq
    );
endinterface

// File: rtl/fp_flag_collector.sv
// Collects FP exception flags into sticky bits and saturating counters, serves
// them through a two-state read port with clear-on-read, and raises a masked irq.
module fp_flag_collector #(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    fp_flag_collector_if.slave  bus
);
    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [3:0]       sticky_q, sticky_d;
    logic [3:0]       mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [CNT_W-1:0] cnt_base [4];
    logic             rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic [CNT_W-1:0] sel_data;
    logic             accept;
    logic             clr_req;

    always_comb begin
        accept   = (state_q == IDLE) && bus.rd_req;
        clr_req  = accept && bus.rd_clr;
        state_d  = state_q;
        sel_data = '0;

        case (bus.rd_sel)
            3'd0: sel_data[7:0] = {mask_q, sticky_q};
            3'd1: sel_data = cnt_q[0];
            3'd2: sel_data = cnt_q[1];
            3'd3: sel_data = cnt_q[2];
            3'd4: sel_data = cnt_q[3];
            default: sel_data = '0;
        endcase

        // A clear and a new event on the same edge keep the event.
        sticky_d = ((clr_req && bus.rd_sel == 3'd0) ? 4'b0000 : sticky_q)
                 | (bus.flag_valid ? bus.flag_in : 4'b0000);

        for (int i = 0; i < 4; i++) begin
            cnt_base[i] = (clr_req && bus.rd_sel == 3'(i + 1)) ? '0 : cnt_q[i];
            if (bus.flag_valid && bus.flag_in[i] && cnt_base[i] != CNT_MAX) begin
                cnt_d[i] = cnt_base[i] + 1'b1;
            end else begin
                cnt_d[i] = cnt_base[i];
            end
        end

        mask_d     = bus.mask_we ? bus.mask_in : mask_q;
        rd_valid_d = accept;
        rd_data_d  = accept ? sel_data : rd_data_q;

        case (state_q)
            IDLE:    if (accept) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sticky_q   <= 4'b0000;
            mask_q     <= 4'hF;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            sticky_q   <= sticky_d;
            mask_q     <= mask_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.sticky   = sticky_q;
    assign bus.irq      = |(sticky_q & ~mask_q);
endmodule

// File: tb/tb_fp_flag_collector.sv
// Directed bench for fp_flag_collector: expected read responses go into a
// scoreboard queue that a negedge monitor pops whenever rd_valid is seen.
module tb_fp_flag_collector;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    logic [7:0] exp_q [$];
    string      name_q [$];

    fp_flag_collector_if #(.CNT_W(8)) bus ();

    fp_flag_collector #(.CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every rd_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_rd_valid: got rd_data=%0h with no read pending", bus.rd_data);
            end else begin
                logic [7:0] e;
                string      n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (bus.rd_data !== e) begin
                    errors++;
                    $display("[TB] FAIL %s: rd_data got %0h expected %0h", n, bus.rd_data, e);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic fv, input logic [3:0] fin,
                                 input logic rq, input logic [2:0] sel, input logic clr);
        bus.flag_valid = fv;
        bus.flag_in    = fin;
        bus.rd_req     = rq;
        bus.rd_sel     = sel;
        bus.rd_clr     = clr;
        @(negedge clk);
    endtask

    task automatic writeMask(input logic [3:0] m);
        bus.mask_we = 1'b1;
        bus.mask_in = m;
        applyStimulus(1'b0, 4'b0, 1'b0, 3'd0, 1'b0);
        bus.mask_we = 1'b0;
    endtask

    // Accept cycle (optionally with a coincident flag event) followed by the RESP cycle.
    task automatic issueRead(input string name, input logic [2:0] sel, input logic clr,
                             input logic [7:0] expected, input logic fv, input logic [3:0] fin);
        exp_q.push_back(expected);
        name_q.push_back(name);
        applyStimulus(fv, fin, 1'b1, sel, clr);
        applyStimulus(1'b0, 4'b0, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, pending=%0d expected 0", exp_q.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [2:0] bb_sel [6];
        logic       bb_clr [6];
        logic [7:0] bb_exp [3];
        int         pulses;

        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.flag_valid = 1'b0;
        bus.flag_in    = 4'b0;
        bus.mask_we    = 1'b0;
        bus.mask_in    = 4'b0;
        bus.rd_req     = 1'b0;
        bus.rd_sel     = 3'd0;
        bus.rd_clr     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_sticky", {4'b0, bus.sticky}, 8'h00);
        checkOutput("reset_irq", {7'b0, bus.irq}, 8'h00);
        checkOutput("reset_rd_valid", {7'b0, bus.rd_valid}, 8'h00);
        checkOutput("reset_rd_data", bus.rd_data, 8'h00);
        reset = 1'b0;

        issueRead("reset_status", 3'd0, 1'b0, 8'hF0, 1'b0, 4'b0);
        checkOutput("reset_irq_after_read", {7'b0, bus.irq}, 8'h00);

        // Overflow events past the counter limit.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 4'b0100, 1'b0, 3'd0, 1'b0);
        end
        applyStimulus(1'b0, 4'b0, 1'b0, 3'd0, 1'b0);
        checkOutput("sat_sticky", {4'b0, bus.sticky}, 8'h04);
        checkOutput("sat_irq_masked", {7'b0, bus.irq}, 8'h00);
        issueRead("sat_cnt2", 3'd3, 1'b0, 8'hFF, 1'b0, 4'b0);
        issueRead("sat_cnt2_clr", 3'd3, 1'b1, 8'hFF, 1'b0, 4'b0);
        issueRead("cnt2_after_clr", 3'd3, 1'b0, 8'h00, 1'b0, 4'b0);
        issueRead("status_clr_f4", 3'd0, 1'b1, 8'hF4, 1'b0, 4'b0);
        checkOutput("sticky_after_clr", {4'b0, bus.sticky}, 8'h00);

        writeMask(4'b0111);
        checkOutput("irq_after_mask", {7'b0, bus.irq}, 8'h00);
        applyStimulus(1'b1, 4'b1000, 1'b0, 3'd0, 1'b0);
        checkOutput("irq_invalid", {7'b0, bus.irq}, 8'h01);
        checkOutput("sticky_invalid", {4'b0, bus.sticky}, 8'h08);
        issueRead("status_irq_clr", 3'd0, 1'b1, 8'h78, 1'b0, 4'b0);
        checkOutput("irq_after_clr", {7'b0, bus.irq}, 8'h00);

        applyStimulus(1'b1, 4'b0010, 1'b0, 3'd0, 1'b0);
        issueRead("status_clr_with_event", 3'd0, 1'b1, 8'h72, 1'b1, 4'b0001);
        checkOutput("sticky_clr_plus_set", {4'b0, bus.sticky}, 8'h01);
        issueRead("cnt0_clr_with_event", 3'd1, 1'b1, 8'h01, 1'b1, 4'b0001);
        issueRead("cnt0_after_clr_inc", 3'd1, 1'b0, 8'h01, 1'b0, 4'b0);
        issueRead("cnt1_value", 3'd2, 1'b0, 8'h01, 1'b0, 4'b0);

        // rd_req held for 6 cycles; odd cycles are RESP, where sel/clr must be ignored.
        bb_sel = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd4, 3'd2};
        bb_clr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        bb_exp = '{8'h71, 8'h01, 8'h01};
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                exp_q.push_back(bb_exp[i / 2]);
                name_q.push_back("b2b_read");
            end
            applyStimulus(1'b0, 4'b0, 1'b1, bb_sel[i], bb_clr[i]);
            if (bus.rd_valid === 1'b1) pulses++;
            checkOutput("b2b_valid_pattern", {7'b0, bus.rd_valid}, (i % 2 == 0) ? 8'h01 : 8'h00);
        end
        applyStimulus(1'b0, 4'b0, 1'b0, 3'd0, 1'b0);
        checkOutput("b2b_pulse_count", 8'(pulses), 8'd3);
        issueRead("b2b_sticky_kept", 3'd0, 1'b0, 8'h71, 1'b0, 4'b0);
        issueRead("b2b_cnt2_kept", 3'd2, 1'b0, 8'h01, 1'b0, 4'b0);

        issueRead("reserved_sel", 3'd6, 1'b1, 8'h00, 1'b0, 4'b0);
        issueRead("status_after_reserved", 3'd0, 1'b0, 8'h71, 1'b0, 4'b0);
        issueRead("cnt0_after_reserved", 3'd1, 1'b0, 8'h01, 1'b0, 4'b0);

        // Reset lands while the FSM is in RESP.
        exp_q.push_back(8'h01);
        name_q.push_back("pre_reset_cnt0");
        applyStimulus(1'b0, 4'b0, 1'b1, 3'd1, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b0, 4'b0, 1'b1, 3'd2, 1'b0);
        checkOutput("midreset_rd_valid", {7'b0, bus.rd_valid}, 8'h00);
        checkOutput("midreset_sticky", {4'b0, bus.sticky}, 8'h00);
        reset = 1'b0;
        applyStimulus(1'b0, 4'b0, 1'b0, 3'd0, 1'b0);
        issueRead("post_reset_cnt0", 3'd1, 1'b0, 8'h00, 1'b0, 4'b0);
        issueRead("post_reset_cnt1", 3'd2, 1'b0, 8'h00, 1'b0, 4'b0);
        issueRead("post_reset_cnt3", 3'd4, 1'b0, 8'h00, 1'b0, 4'b0);
        issueRead("post_reset_status", 3'd0, 1'b0, 8'hF0, 1'b0, 4'b0);

        applyStimulus(1'b0, 4'b0, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b0, 4'b0, 1'b0, 3'd0, 1'b0);
        checkOutput("scoreboard_drained", 8'(exp_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
